// File: rtl/pll_ds_phase_core.sv
// Dynamic-setting PLL output core: div4/div7/div5 quadrature divider, div2 toggle, output mux, fine delay line and lock detect.
// Optional build macro PLL_DS_ICEGATE_EN adds an ICEGATE input that freezes the divider and DIV2 flops.
module pll_ds_phase_core #(
    parameter logic [3:0] FDA_FEEDBACK          = 4'b0000,
    parameter string      DELAY_ADJUSTMENT_MODE = "FIXED",
    parameter int         LOCK_COUNT            = 16
) (
    input  logic       DS_NEGCLK_COUNTER_CLEAR,
    input  logic       RESETB,
`ifdef PLL_DS_ICEGATE_EN
    input  logic       ICEGATE,
`endif
    input  logic [1:0] DIV_MODE_SEL,
    input  logic [1:0] OUT_SEL,
    input  logic [3:0] DLY_ADJ,
    output logic       PHASE0,
    output logic       PHASE90,
    output logic       DIV2,
    output logic       SEL_OUT,
    output logic       DELAYED_OUT,
    output logic       LOCK,
    output logic       DIV_ERR
);

    typedef enum logic [1:0] {
        MODE_DIV4 = 2'b00,
        MODE_DIV7 = 2'b01,
        MODE_BAD  = 2'b10,
        MODE_DIV5 = 2'b11
    } mode_e;

    localparam logic       USE_DYNAMIC = (DELAY_ADJUSTMENT_MODE == "DYNAMIC");
    localparam logic [7:0] LOCK_MAX    = LOCK_COUNT[7:0];

    mode_e       mode_q, mode_d, active_mode;
    logic        fresh_q;
    logic [2:0]  cnt_q, cnt_d, cnt_last, cnt_half;
    logic        phase0_q, phase0_d;
    logic        p1_q, p1_d, p2_q, p2_d;
    logic        div2_q, div2_d;
    logic [14:0] dly_q;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        mode_valid, terminal, lock_clr, advance;
    logic        div_err, phase0_out;
    logic [3:0]  tap_sel;
    logic [15:0] taps;

`ifdef PLL_DS_ICEGATE_EN
    assign advance = ~ICEGATE;
`else
    assign advance = 1'b1;
`endif

    // Until the first edge after reset the mode tracks DIV_MODE_SEL directly.
    assign active_mode = fresh_q ? mode_e'(DIV_MODE_SEL) : mode_q;
    assign mode_valid  = (active_mode != MODE_BAD);
    assign terminal    = (cnt_q == cnt_last);

    always_comb begin
        cnt_last = 3'd3;
        cnt_half = 3'd2;
        case (active_mode)
            MODE_DIV7: begin
                cnt_last = 3'd6;
                cnt_half = 3'd4;
            end
            MODE_DIV5: begin
                cnt_last = 3'd4;
                cnt_half = 3'd3;
            end
            default: begin
                cnt_last = 3'd3;
                cnt_half = 3'd2;
            end
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        phase0_d = phase0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        div2_d   = div2_q;
        mode_d   = active_mode;
        if (advance) begin
            div2_d = ~div2_q;
            if (mode_valid) begin
                cnt_d    = terminal ? 3'd0 : cnt_q + 3'd1;
                phase0_d = (cnt_q < cnt_half);
                p1_d     = phase0_q;
                p2_d     = p1_q;
                // New mode only lands on the terminal count, so the period in flight completes.
                if (terminal) begin
                    mode_d = mode_e'(DIV_MODE_SEL);
                end
            end else begin
                cnt_d    = 3'd0;
                phase0_d = 1'b0;
                p1_d     = 1'b0;
                p2_d     = 1'b0;
                mode_d   = mode_e'(DIV_MODE_SEL);
            end
        end
    end

    always_comb begin
        lock_clr   = !mode_valid || (mode_d != active_mode);
        lock_cnt_d = lock_cnt_q;
        if (lock_clr) begin
            lock_cnt_d = 8'd0;
        end else if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge DS_NEGCLK_COUNTER_CLEAR or negedge RESETB) begin
        if (!RESETB) begin
            mode_q     <= MODE_DIV4;
            fresh_q    <= 1'b1;
            cnt_q      <= 3'd0;
            phase0_q   <= 1'b0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            div2_q     <= 1'b0;
            lock_cnt_q <= 8'd0;
            dly_q      <= 15'd0;
        end else begin
            mode_q     <= mode_d;
            fresh_q    <= 1'b0;
            cnt_q      <= cnt_d;
            phase0_q   <= phase0_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            div2_q     <= div2_d;
            lock_cnt_q <= lock_cnt_d;
            dly_q      <= {dly_q[13:0], phase0_out};
        end
    end

    assign div_err    = ~fresh_q & (mode_q == MODE_BAD);
    assign phase0_out = phase0_q & ~div_err;

    assign PHASE0  = phase0_out;
    assign PHASE90 = ((active_mode == MODE_DIV7) ? p2_q : p1_q) & ~div_err;
    assign DIV2    = div2_q;
    assign DIV_ERR = div_err;
    assign LOCK    = (lock_cnt_q == LOCK_MAX);

    always_comb begin
        SEL_OUT = 1'b0;
        case (OUT_SEL)
            2'b00:   SEL_OUT = phase0_out;
            2'b01:   SEL_OUT = PHASE90;
            2'b10:   SEL_OUT = div2_q;
            default: SEL_OUT = DS_NEGCLK_COUNTER_CLEAR;
        endcase
    end

    // Tap 0 is the undelayed PHASE0; tap k is the k-th shift stage.
    assign tap_sel     = USE_DYNAMIC ? DLY_ADJ : FDA_FEEDBACK;
    assign taps        = {dly_q, phase0_out};
    assign DELAYED_OUT = taps[tap_sel];

endmodule

// File: tb/tb_pll_ds_phase_core.sv
// Scoreboard bench for pll_ds_phase_core: a DYNAMIC instance and a FIXED (tap 5) instance share stimulus.
module tb_pll_ds_phase_core;

    localparam int LC = 6;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       icegate = 1'b0;
    logic [1:0] div_mode_sel = 2'b00;
    logic [1:0] out_sel = 2'b00;
    logic [3:0] dly_adj = 4'd0;

    logic phase0, phase90, div2, sel_out, delayed_out, lock, div_err;
    logic f_phase0, f_phase90, f_div2, f_sel_out, f_delayed_out, f_lock, f_div_err;

    // exp entry: [15:8] compare mask, [7:0] expected value
    // field bit order: phase0, phase90, div2, sel_out, delayed_out, lock, div_err, fixed delayed_out
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic [7:0]  act;
    int          checks = 0;
    int          errors = 0;
    int          vec_idx = 0;

    always #5 clk = ~clk;

    pll_ds_phase_core #(
        .FDA_FEEDBACK(4'd9),
        .DELAY_ADJUSTMENT_MODE("DYNAMIC"),
        .LOCK_COUNT(LC)
    ) dut_dyn (
        .DS_NEGCLK_COUNTER_CLEAR(clk),
        .RESETB(resetb),
`ifdef PLL_DS_ICEGATE_EN
        .ICEGATE(icegate),
`endif
        .DIV_MODE_SEL(div_mode_sel),
        .OUT_SEL(out_sel),
        .DLY_ADJ(dly_adj),
        .PHASE0(phase0),
        .PHASE90(phase90),
        .DIV2(div2),
        .SEL_OUT(sel_out),
        .DELAYED_OUT(delayed_out),
        .LOCK(lock),
        .DIV_ERR(div_err)
    );

    pll_ds_phase_core #(
        .FDA_FEEDBACK(4'd5),
        .DELAY_ADJUSTMENT_MODE("FIXED"),
        .LOCK_COUNT(16)
    ) dut_fix (
        .DS_NEGCLK_COUNTER_CLEAR(clk),
        .RESETB(resetb),
`ifdef PLL_DS_ICEGATE_EN
        .ICEGATE(icegate),
`endif
        .DIV_MODE_SEL(div_mode_sel),
        .OUT_SEL(out_sel),
        .DLY_ADJ(dly_adj),
        .PHASE0(f_phase0),
        .PHASE90(f_phase90),
        .DIV2(f_div2),
        .SEL_OUT(f_sel_out),
        .DELAYED_OUT(f_delayed_out),
        .LOCK(f_lock),
        .DIV_ERR(f_div_err)
    );

    function automatic string fname(input int i);
        case (i)
            0: return "phase0";
            1: return "phase90";
            2: return "div2";
            3: return "sel_out";
            4: return "delayed_out";
            5: return "lock";
            6: return "div_err";
            default: return "fixed_delayed_out";
        endcase
    endfunction

    function automatic logic [1:0] enc(input byte c);
        case (c)
            "1": return 2'b11;
            "0": return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Monitor: one expected entry per falling edge, whenever the scoreboard holds one.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            act = {f_delayed_out, div_err, lock, delayed_out, sel_out, div2, phase90, phase0};
            for (int i = 0; i < 8; i++) begin
                if (exp_w[8+i]) begin
                    checks++;
                    if (act[i] !== exp_w[i]) begin
                        errors++;
                        $display("FAIL %s vec %0d got %b expected %b", fname(i), vec_idx, act[i], exp_w[i]);
                    end
                end
            end
            vec_idx++;
        end
    end

    task automatic push_zero();
        exp_q.push_back({8'hFF, 8'h00});
    endtask

    // Driver is always positioned 1 time unit after a falling edge.
    task automatic do_reset(input logic [1:0] mode, input logic [1:0] osel, input logic [3:0] dly);
        resetb       = 1'b0;
        div_mode_sel = mode;
        out_sel      = osel;
        dly_adj      = dly;
        push_zero();
        @(negedge clk); #1;
        push_zero();
        @(negedge clk); #1;
        resetb = 1'b1;
    endtask

    task automatic run(input logic [1:0] mode, input logic [1:0] osel, input logic [3:0] dly,
                       input string p0, input string p90, input string d2, input string sl,
                       input string dl, input string lk, input string er, input string fx);
        string fs[8];
        string s;
        logic [7:0] m;
        logic [7:0] v;
        logic [1:0] e;
        fs[0] = p0; fs[1] = p90; fs[2] = d2; fs[3] = sl;
        fs[4] = dl; fs[5] = lk;  fs[6] = er; fs[7] = fx;
        for (int i = 0; i < p0.len(); i++) begin
            div_mode_sel = mode;
            out_sel      = osel;
            dly_adj      = dly;
            m = 8'h00;
            v = 8'h00;
            for (int j = 0; j < 8; j++) begin
                s = fs[j];
                e = enc(s[i]);
                m[j] = e[1];
                v[j] = e[0];
            end
            exp_q.push_back({m, v});
            @(negedge clk); #1;
        end
    endtask

    task automatic async_reset_mid();
        push_zero();
        @(posedge clk); #2;
        resetb       = 1'b0;
        div_mode_sel = 2'b00;
        out_sel      = 2'b00;
        dly_adj      = 4'd0;
        @(negedge clk); #1;
        push_zero();
        @(negedge clk); #1;
        resetb = 1'b1;
    endtask

    task automatic div4_from_reset();
        run(2'b00, 2'b00, 4'd0, "110011001100", "011001100110", "101010101010", "110011001100",
            "110011001100", "000001111111", "000000000000", "000001100110");
    endtask

    initial begin
        @(negedge clk); #1;

        // div4 from reset, then OUT_SEL and DLY_ADJ sweeps
        do_reset(2'b00, 2'b00, 4'd0);
        div4_from_reset();
        run(2'b00, 2'b01, 4'd3, "1100", "0110", "1010", "0110", "1001", "1111", "0000", "0110");
        run(2'b00, 2'b10, 4'd15, "1100", "0110", "1010", "1010", "1001", "1111", "0000", "0110");
        run(2'b00, 2'b00, 4'd0, "1", "0", "1", "1", "1", "1", "0", "0");

        // div4 -> div5 mid-period: old period completes, LOCK low for LC edges
        run(2'b11, 2'b00, 4'd0, "10011100111001", "11001110011100", "01010101010101", "10011100111001",
            "10011100111001", "11000000111111", "00000000000000", "11001100111001");

        // invalid mode, then back to div4
        run(2'b10, 2'b00, 4'd0, "1100000", "1110000", "0101010", "1100000",
            "1100000", "1110000", "0001111", "1100111");
        run(2'b00, 2'b00, 4'd0, "01100110", "00110011", "10101010", "01100110",
            "01100110", "00000011", "00000000", "00000011");

        // div7 from reset, PHASE90 two edges behind
        do_reset(2'b01, 2'b01, 4'd0);
        run(2'b01, 2'b01, 4'd0, "11110001111000", "00111100011110", "10101010101010", "00111100011110",
            "11110001111000", "00000111111111", "00000000000000", "00000111100011");

        // div5 from reset, clock pass-through select sampled low
        do_reset(2'b11, 2'b11, 4'd3);
        run(2'b11, 2'b11, 4'd3, "1110011100", "0111001110", "1010101010", "0000000000",
            "0001110011", "0000011111", "0000000000", "0000011100");

        // reset between edges, then the div4 pattern again
        async_reset_mid();
        div4_from_reset();

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
